uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with input FIFO. Accepts words over a valid/ready handshake,

---
 rtl/uart_tx_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter fed by a small word FIFO. Words arrive over a valid/ready
// handshake, are buffered, and are serialised LSB-first as
// start / data / [parity] / stop frames. Consecutive frames are sent with no
// idle gap whenever the FIFO still holds a word at the end of a stop bit.
// The serial line is driven straight from a flop so it never glitches.

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BIT_W    = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);
  localparam logic             PAR_ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_head;

  // The extra pointer MSB separates "full" (MSBs differ, rest equal) from
  // "empty" (pointers identical) without a separate occupancy counter.
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_head  = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  // Ready depends only on stored state, so a pop in the same cycle never
  // opens a slot for a push while the FIFO is full.
  assign tx_ready   = ~fifo_full;
  assign push       = tx_valid & tx_ready;

  // Pointer update: reset clears both, push and pop advance independently.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are only ever read between the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; clearing the pointers already
    // makes every entry unreachable, and a resettable array costs a flop
    // per bit instead of a RAM.
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 bit_end;
  logic                 txd_d;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and pop decision; a pop always coincides with entering START.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt == DATA_LAST))
          state_d = HAS_PARITY ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end && (bit_cnt == STOP_LAST)) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the current state; registered below before reaching the pin.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
      S_PARITY: txd_d = par_q;
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // Bit timing, shift register and parity capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      // The baud counter restarts on every bit boundary and rests at zero in
      // IDLE, so each frame starts with a fresh, drift-free bit period.
      if (state_q == S_IDLE || bit_end) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + 1'b1;

      // bit_cnt indexes data bits in DATA and stop bits in STOP.
      if (bit_end && (state_q == S_DATA)) begin
        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
      end else if (bit_end && (state_q == S_STOP)) begin
        bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + 1'b1;
      end

      // Parity is computed once at load time from the whole word.
      if (pop) begin
        shift_q <= fifo_head;
        par_q   <= (^fifo_head) ^ PAR_ODD;
      end else if (bit_end && (state_q == S_DATA)) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

  // Serial output flop; reset forces the line idle immediately.
  always_ff @(posedge clk) begin
    if (rst) uart_txd <= 1'b1;
    else     uart_txd <= txd_d;
  end

  assign busy = (state_q != S_IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: six parameter sets run side by side, each
// compared every cycle against a queue-based line model, plus directed
// literal checks for the key frame shapes.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int NC   = 6;
  localparam int BAUD = 10;   // 1 MHz / 100 kbaud

  function automatic int cfg_db(int i);
    case (i)
      1: return 7;
      4: return 9;
      5: return 7;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_par(int i);
    case (i)
      1: return 2;
      4: return 1;
      5: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_sb(int i);
    case (i)
      2: return 2;
      5: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_depth(int i);
    case (i)
      3: return 4;
      4: return 4;
      5: return 8;
      default: return 16;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic [8:0]    tx_data    [NC];
  logic [NC-1:0] tx_valid;
  logic [NC-1:0] tx_ready;
  logic [NC-1:0] uart_txd;
  logic [NC-1:0] busy;
  logic [5:0]    fifo_level [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int DB  = cfg_db(g);
    localparam int LW  = $clog2(cfg_depth(g)) + 1;
    logic [LW-1:0] lvl;
    uart_tx_fifo #(
      .CLK_FREQ  (1_000_000),
      .UART_BPS  (100_000),
      .DATA_BITS (DB),
      .PARITY    (cfg_par(g)),
      .STOP_BITS (cfg_sb(g)),
      .FIFO_DEPTH(cfg_depth(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data[g][DB-1:0]),
      .tx_valid  (tx_valid[g]),
      .tx_ready  (tx_ready[g]),
      .uart_txd  (uart_txd[g]),
      .busy      (busy[g]),
      .fifo_level(lvl)
    );
    assign fifo_level[g] = {{(6-LW){1'b0}}, lvl};
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue of words plus the pop time of the frame on the
  // line. Frame k covers the cycles after edges p+1 .. p+F, one bit per BAUD.
  // ---------------------------------------------------------------------------
  int       cyc = 0;
  bit       model_on = 1'b0;
  bit [8:0] mq [NC][$];
  bit       fr_act  [NC];
  int       fr_p    [NC];
  bit [8:0] fr_w    [NC];
  int       free_at [NC];
  bit       e_txd   [NC];
  bit       e_busy  [NC];
  bit       e_ready [NC];
  int       e_lvl   [NC];

  function automatic int frame_len(int i);
    return (1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i)) * BAUD;
  endfunction

  function automatic bit frame_bit(int i, bit [8:0] w, int idx);
    int db   = cfg_db(i);
    int ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= db) return w[idx-1];
    if (cfg_par(i) != 0 && idx == db + 1) begin
      for (int k = 0; k < db; k++) ones += int'(w[k]);
      return (cfg_par(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        mq[i].delete();
        fr_act[i]  = 1'b0;
        free_at[i] = cyc;
        e_txd[i]   = 1'b1;
      end else begin
        int  sz;
        bit  do_pop;
        bit  do_push;
        e_txd[i] = 1'b1;
        if (fr_act[i] && cyc >= fr_p[i] + 1 && cyc <= fr_p[i] + frame_len(i))
          e_txd[i] = frame_bit(i, fr_w[i], (cyc - fr_p[i] - 1) / BAUD);
        sz      = mq[i].size();
        do_pop  = (cyc >= free_at[i]) && (sz > 0);
        do_push = tx_valid[i] && (sz < cfg_depth(i));
        if (do_pop) begin
          fr_w[i]    = mq[i].pop_front();
          fr_p[i]    = cyc;
          fr_act[i]  = 1'b1;
          free_at[i] = cyc + frame_len(i);
        end
        if (do_push) mq[i].push_back(tx_data[i] & 9'((1 << cfg_db(i)) - 1));
      end
      e_busy[i]  = (fr_act[i] && cyc < fr_p[i] + frame_len(i)) || (mq[i].size() != 0);
      e_lvl[i]   = mq[i].size();
      e_ready[i] = (mq[i].size() < cfg_depth(i));
    end
    if (rst) model_on = 1'b1;
  end

  // Every-cycle comparison against the model, sampled mid-period.
  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < NC; i++) begin
        check($sformatf("txd[%0d]@%0d", i, cyc), 32'(uart_txd[i]), 32'(e_txd[i]));
        check($sformatf("busy[%0d]@%0d", i, cyc), 32'(busy[i]), 32'(e_busy[i]));
        check($sformatf("ready[%0d]@%0d", i, cyc), 32'(tx_ready[i]), 32'(e_ready[i]));
        check($sformatf("level[%0d]@%0d", i, cyc), 32'(fifo_level[i]), 32'(e_lvl[i]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic at_edge(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push1(input int i, input logic [8:0] d, output int n);
    @(negedge clk);
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    @(negedge clk);
    n           = cyc;
    tx_valid[i] = 1'b0;
  endtask

  // Literal frame check: bit j (start first) sampled mid-bit after acceptance n.
  task automatic check_frame_lit(input int i, input int n, input logic [11:0] bits,
                                 input int nb, input string tag);
    for (int j = 0; j < nb; j++) begin
      at_edge(n + 2 + BAUD * j + BAUD / 2);
      check($sformatf("%s bit%0d", tag, j), 32'(uart_txd[i]), 32'(bits[j]));
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget = 4000;
    while (busy != '0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, " drain"}, 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [8:0] t4_words [6];
  logic [7:0] t4_rx    [6];

  initial begin
    int n;
    int m;
    int peak;
    bit saw_full;
    rst      = 1'b1;
    tx_valid = '0;
    for (int i = 0; i < NC; i++) tx_data[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset txd", 32'(uart_txd[0]), 32'(1));
    check("reset busy", 32'(busy), 32'(0));
    check("reset ready", 32'(tx_ready), 32'({NC{1'b1}}));
    check("reset level", 32'(fifo_level[0]), 32'(0));

    // T1: 8N1 0xA5, start bit two edges after acceptance.
    push1(0, 9'h0A5, n);
    check("t1 level at accept", 32'(fifo_level[0]), 32'(1));
    at_edge(n + 1);
    check("t1 line before start", 32'(uart_txd[0]), 32'(1));
    check("t1 level after pop", 32'(fifo_level[0]), 32'(0));
    at_edge(n + 2);
    check("t1 start edge", 32'(uart_txd[0]), 32'(0));
    check_frame_lit(0, n, 12'b0011_0100_1010, 10, "t1");
    at_edge(n + 102);
    check("t1 busy after", 32'(busy[0]), 32'(0));
    check("t1 line after", 32'(uart_txd[0]), 32'(1));
    wait_idle("t1");

    // T2: 7 data bits, even then odd parity.
    push1(1, 9'h055, n);
    check_frame_lit(1, n, 12'b0010_1010_1010, 10, "t2 even");
    push1(5, 9'h055, n);
    check_frame_lit(5, n, 12'b0111_1010_1010, 11, "t2 odd");
    wait_idle("t2");

    // T3: 8N2 back-to-back frames, 110 cycles apart.
    @(negedge clk);
    tx_valid[2] = 1'b1;
    tx_data[2]  = 9'h001;
    @(negedge clk);
    n = cyc;
    tx_data[2] = 9'h002;
    @(negedge clk);
    tx_data[2] = 9'h003;
    @(negedge clk);
    tx_valid[2] = 1'b0;
    peak = 0;
    for (int t = n + 2; t <= n + 332; t++) begin
      at_edge(t);
      if (int'(fifo_level[2]) > peak) peak = int'(fifo_level[2]);
      if (t == n + 111 || t == n + 221) check($sformatf("t3 stop @+%0d", t - n), 32'(uart_txd[2]), 32'(1));
      if (t == n + 112 || t == n + 222) check($sformatf("t3 start @+%0d", t - n), 32'(uart_txd[2]), 32'(0));
      if (t == n + 330) check("t3 busy late", 32'(busy[2]), 32'(1));
      if (t == n + 332) check("t3 busy end", 32'(busy[2]), 32'(0));
    end
    check("t3 peak level", 32'(peak), 32'(2));
    wait_idle("t3");

    // T4: depth 4, six words held on tx_valid; line decoded independently.
    for (int k = 0; k < 6; k++) t4_words[k] = 9'($urandom_range(0, 255));
    saw_full = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int budget = 500;
          tx_data[3]  = t4_words[k];
          tx_valid[3] = 1'b1;
          while (!tx_ready[3] && budget > 0) begin
            if (fifo_level[3] == 6'd4) saw_full = 1'b1;
            @(negedge clk);
            budget--;
          end
          @(negedge clk);
        end
        tx_valid[3] = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          int budget = 2000;
          while (uart_txd[3] && budget > 0) begin
            @(negedge clk);
            budget--;
          end
          m = cyc;
          at_edge(m + BAUD / 2);
          check($sformatf("t4 start%0d", k), 32'(uart_txd[3]), 32'(0));
          for (int b = 0; b < 8; b++) begin
            at_edge(m + BAUD / 2 + BAUD * (b + 1));
            t4_rx[k][b] = uart_txd[3];
          end
          at_edge(m + BAUD / 2 + BAUD * 9);
          check($sformatf("t4 stop%0d", k), 32'(uart_txd[3]), 32'(1));
          check($sformatf("t4 byte%0d", k), 32'(t4_rx[k]), 32'(t4_words[k][7:0]));
        end
      end
    join
    check("t4 saw full", 32'(saw_full), 32'(1));
    wait_idle("t4");

    // T5: reset during data bit 3 with two words queued.
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 9'h011;
    @(negedge clk);
    n = cyc;
    tx_data[0] = 9'h022;
    @(negedge clk);
    tx_data[0] = 9'h033;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    at_edge(n + 44);
    check("t5 level before rst", 32'(fifo_level[0]), 32'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 txd after rst", 32'(uart_txd[0]), 32'(1));
    check("t5 level after rst", 32'(fifo_level[0]), 32'(0));
    check("t5 busy after rst", 32'(busy[0]), 32'(0));
    push1(0, 9'h03C, n);
    check_frame_lit(0, n, 12'b0010_0111_1000, 10, "t5 0x3C");
    wait_idle("t5");

    // T6: 9 data bits, odd parity, 120-cycle frame.
    push1(4, 9'h1FF, n);
    check_frame_lit(4, n, 12'b1011_1111_1110, 12, "t6");
    at_edge(n + 120);
    check("t6 busy last", 32'(busy[4]), 32'(1));
    at_edge(n + 121);
    check("t6 busy done", 32'(busy[4]), 32'(0));
    wait_idle("t6");

    // Random traffic with varying density and occasional resets.
    for (int blk = 0; blk < 10; blk++) begin
      int dens = $urandom_range(0, 100);
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        rst = ($urandom_range(0, 1499) == 0);
        for (int i = 0; i < NC; i++) begin
          tx_valid[i] = ($urandom_range(0, 99) < dens);
          tx_data[i]  = 9'($urandom_range(0, 511));
        end
      end
    end
    @(negedge clk);
    rst      = 1'b0;
    tx_valid = '0;
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
